// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants and state encoding for the four-way memory port arbiter.
package mem_port_arbiter_pkg;

    localparam int unsigned NUM_REQ           = 4;
    localparam int unsigned SEL_W             = 2;
    localparam int unsigned DEFAULT_MAX_BURST = 8;

    typedef enum logic {
        StIdle = 1'b0,
        StOwn  = 1'b1
    } arb_state_e;

endpackage

// File: rtl/mem_port_arbiter_rr_pick4.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping mod 4.
module rr_pick4
    import mem_port_arbiter_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [SEL_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] onehot,
    output logic [SEL_W-1:0]   idx,
    output logic               any
);

    logic [SEL_W-1:0] cand;

    always_comb begin
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        cand   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = ptr + SEL_W'(k);
            if (!any && req[cand]) begin
                any    = 1'b1;
                idx    = cand;
                onehot = NUM_REQ'(1) << cand;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin owner of the shared memory port: grants bursts, counts beats, releases fairly.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned MAX_BURST = DEFAULT_MAX_BURST
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] last,
    input  logic               bus_ready,
    output logic [SEL_W-1:0]   sel,
    output logic [NUM_REQ-1:0] gnt,
    output logic               bus_valid,
    output logic [NUM_REQ-1:0] beat_ack,
    output logic               busy
);

    localparam int unsigned    CNT_W   = $clog2(MAX_BURST) + 1;
    localparam logic [CNT_W-1:0] max_cnt = CNT_W'(MAX_BURST);

    arb_state_e         state_q, state_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [SEL_W-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               own, accept, owner_drop, release_own;
    logic [CNT_W-1:0]   cnt_inc;
    logic [SEL_W-1:0]   pick_ptr;
    logic [NUM_REQ-1:0] pick_req, pick_onehot;
    logic [SEL_W-1:0]   pick_idx;
    logic               pick_any;

    assign own         = (state_q == StOwn);
    assign bus_valid   = own & req[sel_q];
    assign accept      = bus_valid & bus_ready;
    assign cnt_inc     = cnt_q + CNT_W'(1);
    assign owner_drop  = own & ~req[sel_q];
    assign release_own = owner_drop | (accept & (last[sel_q] | (cnt_inc == max_cnt)));

    // On release the owner moves to lowest priority; a dropped owner is excluded entirely.
    assign pick_ptr = own ? sel_q + SEL_W'(1) : ptr_q;
    assign pick_req = owner_drop ? (req & ~gnt_q) : req;

    rr_pick4 u_pick (
        .req    (pick_req),
        .ptr    (pick_ptr),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (pick_any) begin
                    state_d = StOwn;
                    gnt_d   = pick_onehot;
                    sel_d   = pick_idx;
                    cnt_d   = '0;
                end
            end
            StOwn: begin
                if (release_own) begin
                    ptr_d = sel_q + SEL_W'(1);
                    cnt_d = '0;
                    if (pick_any) begin
                        gnt_d = pick_onehot;
                        sel_d = pick_idx;
                    end else begin
                        state_d = StIdle;
                        gnt_d   = '0;
                    end
                end else if (accept) begin
                    cnt_d = cnt_inc;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= StIdle;
            gnt_q   <= '0;
            sel_q   <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign gnt      = gnt_q;
    assign sel      = sel_q;
    assign beat_ack = gnt_q & {NUM_REQ{accept}};
    assign busy     = own;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized and directed bench for mem_port_arbiter against an integer-level ownership model.
module tb_mem_port_arbiter;

    localparam int MAX = 8;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic [3:0] req = '0;
    logic [3:0] last = '0;
    logic       bus_ready = 1'b0;
    logic [1:0] sel;
    logic [3:0] gnt;
    logic       bus_valid;
    logic [3:0] beat_ack;
    logic       busy;

    int n_checks = 0;
    int n_errors = 0;
    string phase = "init";

    // Reference model: who owns the port (-1 = nobody), the scan start, beats taken.
    int m_owner = -1;
    int m_sel   = 0;
    int m_ptr   = 0;
    int m_cnt   = 0;

    logic [3:0] obs_gnt;
    logic [3:0] obs_ack;

    mem_port_arbiter #(.MAX_BURST(MAX)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .req       (req),
        .last      (last),
        .bus_ready (bus_ready),
        .sel       (sel),
        .gnt       (gnt),
        .bus_valid (bus_valid),
        .beat_ack  (beat_ack),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s/%s at %0t: got %0h expected %0h", phase, tag, $time, got, exp);
        end
    endtask

    function automatic int pick(input logic [3:0] r, input int p);
        for (int k = 0; k < 4; k++) begin
            if (r[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_sel   = 0;
        m_ptr   = 0;
        m_cnt   = 0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".gnt"}, 32'(gnt), 32'd0);
        check({tag, ".sel"}, 32'(sel), 32'd0);
        check({tag, ".valid"}, 32'(bus_valid), 32'd0);
        check({tag, ".ack"}, 32'(beat_ack), 32'd0);
        check({tag, ".busy"}, 32'(busy), 32'd0);
    endtask

    // One clock cycle: drive, compare outputs with the model, then advance the model.
    task automatic step(input logic [3:0] r, input logic [3:0] l, input logic rdy);
        logic [3:0] e_gnt, e_ack, mr;
        logic       e_busy, e_bv, acc, drop;
        int         w;
        @(negedge clk);
        req = r;
        last = l;
        bus_ready = rdy;
        #1;
        e_busy = (m_owner >= 0);
        e_gnt  = e_busy ? 4'(1 << m_owner) : 4'd0;
        e_bv   = e_busy && r[m_owner];
        e_ack  = (e_bv && rdy) ? e_gnt : 4'd0;
        check("gnt", 32'(gnt), 32'(e_gnt));
        check("sel", 32'(sel), 32'(m_sel));
        check("bus_valid", 32'(bus_valid), 32'(e_bv));
        check("beat_ack", 32'(beat_ack), 32'(e_ack));
        check("busy", 32'(busy), 32'(e_busy));
        obs_gnt = gnt;
        obs_ack = beat_ack;
        if (!rstn) return;
        if (m_owner < 0) begin
            w = pick(r, m_ptr);
            if (w >= 0) begin
                m_owner = w;
                m_sel   = w;
                m_cnt   = 0;
            end
        end else begin
            acc  = e_bv && rdy;
            drop = !r[m_owner];
            if (acc) m_cnt++;
            if (drop || (acc && (l[m_owner] || m_cnt == MAX))) begin
                m_ptr = (m_owner + 1) % 4;
                mr = r;
                if (drop) mr[m_owner] = 1'b0;
                w = pick(mr, m_ptr);
                m_cnt = 0;
                if (w >= 0) begin
                    m_owner = w;
                    m_sel   = w;
                end else begin
                    m_owner = -1;
                end
            end
        end
    endtask

    task automatic sync_reset();
        @(negedge clk);
        rstn = 1'b0;
        req = '0;
        #1;
        model_reset();
        @(negedge clk);
        rstn = 1'b1;
    endtask

    // Reset asserted between clock edges; outputs must clear without waiting for an edge.
    task automatic async_reset(input string tag);
        @(posedge clk);
        #2;
        rstn = 1'b0;
        #1;
        model_reset();
        check_all_zero(tag);
    endtask

    task automatic release_reset();
        @(negedge clk);
        req = '0;
        rstn = 1'b1;
    endtask

    initial begin
        int         ack1;
        logic [3:0] rq;

        // Reset held with random requests, then released with no requests.
        phase = "reset";
        for (int i = 0; i < 4; i++) step(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'b1);
        check_all_zero("reset_hold");
        release_reset();
        for (int i = 0; i < 3; i++) step(4'b0000, 4'b0000, 1'b1);
        check("idle_after_reset", 32'(busy), 32'd0);

        // Single burst of three beats from requester 2.
        phase = "single";
        sync_reset();
        ack1 = 0;
        step(4'b0100, 4'b0000, 1'b1);
        step(4'b0100, 4'b0000, 1'b1);
        check("c1_gnt", 32'(obs_gnt), 32'h4);
        check("c1_sel", 32'(sel), 32'd2);
        if (obs_ack[2]) ack1++;
        step(4'b0100, 4'b0000, 1'b1);
        if (obs_ack[2]) ack1++;
        step(4'b0100, 4'b0100, 1'b1);
        if (obs_ack[2]) ack1++;
        check("three_beats", 32'(ack1), 32'd3);
        step(4'b0000, 4'b0000, 1'b1);
        step(4'b0000, 4'b0000, 1'b1);
        check("idle_gnt", 32'(obs_gnt), 32'd0);
        check("idle_sel_held", 32'(sel), 32'd2);
        check("idle_busy", 32'(busy), 32'd0);
        step(4'b1111, 4'b1111, 1'b1);
        step(4'b0000, 4'b0000, 1'b1);
        check("ptr_after_release", 32'(obs_gnt), 32'h8);

        // Fairness: everyone requesting single-beat bursts.
        phase = "fair";
        sync_reset();
        step(4'b1111, 4'b1111, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step(4'b1111, 4'b1111, 1'b1);
            check("rr_owner", 32'(obs_gnt), 32'(1 << (i % 4)));
            check("rr_busy", 32'(busy), 32'd1);
        end

        // Forced release at MAX_BURST beats.
        phase = "maxburst";
        sync_reset();
        ack1 = 0;
        for (int i = 0; i < 9; i++) begin
            step(4'b1010, 4'b0000, 1'b1);
            if (obs_ack[1]) ack1++;
        end
        check("beats_before_release", 32'(ack1), 32'(MAX));
        step(4'b1010, 4'b0000, 1'b1);
        check("next_owner", 32'(obs_gnt), 32'h8);

        // Stall mid-burst.
        phase = "stall";
        sync_reset();
        for (int i = 0; i < 3; i++) step(4'b0001, 4'b0000, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step(4'b0001, 4'($urandom_range(0, 15)), 1'b0);
            check("stall_valid", 32'(bus_valid), 32'd1);
            check("stall_ack", 32'(obs_ack), 32'd0);
        end
        step(4'b0001, 4'b0000, 1'b1);
        check("resume_ack", 32'(obs_ack), 32'h1);
        step(4'b0001, 4'b0001, 1'b1);
        step(4'b0000, 4'b0000, 1'b1);

        // Abort by dropping request, then asynchronous reset mid-burst.
        phase = "abort";
        sync_reset();
        for (int i = 0; i < 3; i++) step(4'b0100, 4'b0000, 1'b1);
        step(4'b1000, 4'b0000, 1'b1);
        check("abort_no_beat", 32'(obs_ack), 32'd0);
        step(4'b1000, 4'b0000, 1'b1);
        check("abort_next_owner", 32'(obs_gnt), 32'h8);
        async_reset("async_mid_burst");
        step(4'b1111, 4'b0000, 1'b1);
        release_reset();

        // Random traffic with occasional asynchronous resets.
        phase = "random";
        rq = '0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                async_reset("async_random");
                step(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'b1);
                release_reset();
            end else begin
                for (int b = 0; b < 4; b++) if ($urandom_range(0, 3) == 0) rq[b] = ~rq[b];
                step(rq,
                     {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                      ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)},
                     ($urandom_range(0, 3) != 0));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
